// File: rtl/i2s_pkg.sv
// Shared constants, state type and slot helper for the I2S microphone receiver.
package i2s_pkg;

  localparam int SAMPLE_W   = 18;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rx_state_t;

  // First bit position of the slot for a channel (0 = left, 1 = right).
  function automatic logic [BIT_CNT_W-1:0] slot_base(input int channel);
    return (channel != 0) ? BIT_CNT_W'(SLOT_BITS) : '0;
  endfunction

endpackage

// File: rtl/i2s_mic_rx_if.sv
// Pad and sample-side signals of one I2S microphone receiver.
interface i2s_mic_rx_if;

  logic                            en;
  logic                            i2s_sd;
  logic                            i2s_bclk;
  logic                            i2s_ws;
  logic [i2s_pkg::SAMPLE_W-1:0]    data;
  logic                            data_rdy;
  logic                            running;

  // master: the receiver itself; slave: whoever drives en/sd and consumes samples
  modport master (
    input  en, i2s_sd,
    output i2s_bclk, i2s_ws, data, data_rdy, running
  );

  modport slave (
    output en, i2s_sd,
    input  i2s_bclk, i2s_ws, data, data_rdy, running
  );

endinterface

// File: rtl/i2s_clock_gen.sv
// I2S bit clock / word select generator with rise/fall strobes and bit position.
module i2s_clock_gen import i2s_pkg::*; #(
  parameter int CLK_DIV = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en_clk,
  output logic                 i2s_bclk,
  output logic                 i2s_ws,
  output logic                 bclk_rise,
  output logic                 bclk_fall,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt;

  assign bit_cnt_nxt = bit_cnt + 1'b1;

  // Strobes are registered alongside the bclk toggle, so they are high in the
  // first cycle the new bclk level is visible; bit_cnt advances with the fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_ws    <= 1'b0;
      bclk_rise <= 1'b0;
      bclk_fall <= 1'b0;
      bit_cnt   <= '0;
    end else if (!en_clk) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_ws    <= 1'b0;
      bclk_rise <= 1'b0;
      bclk_fall <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      bclk_rise <= 1'b0;
      bclk_fall <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (i2s_bclk) begin
          bclk_fall <= 1'b1;
          bit_cnt   <= bit_cnt_nxt;
          i2s_ws    <= bit_cnt_nxt[BIT_CNT_W-1];
        end else begin
          bclk_rise <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for one 18-bit MEMS microphone: clocks the mic, discards
// start-up frames, then publishes the selected slot once per frame.
//   state  | meaning
//   IDLE   | bclk/ws parked low, counters cleared, waiting for en
//   WARMUP | clocks running, frames counted, samples not published
//   RUN    | clocks running, each completed slot word published
module i2s_mic_rx import i2s_pkg::*; #(
  parameter int CLK_DIV       = 16,
  parameter int CHANNEL       = 0,
  parameter int WARMUP_FRAMES = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  i2s_mic_rx_if.master     mic
);

  localparam int FRAME_CNT_W = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
  localparam logic [FRAME_CNT_W-1:0] FRAME_TARGET = FRAME_CNT_W'(WARMUP_FRAMES);
  localparam logic [BIT_CNT_W-1:0]   SLOT_FIRST   = slot_base(CHANNEL) + 1'b1;
  localparam logic [BIT_CNT_W-1:0]   SLOT_LAST    = slot_base(CHANNEL) + BIT_CNT_W'(SAMPLE_W);

  rx_state_t               state;
  logic                    sd_meta;
  logic                    sd_sync;
  logic [SAMPLE_W-1:0]     shift;
  logic [SAMPLE_W-1:0]     shift_nxt;
  logic [FRAME_CNT_W-1:0]  frame_cnt;
  logic [FRAME_CNT_W-1:0]  frame_cnt_inc;
  logic [SAMPLE_W-1:0]     data_q;
  logic                    data_rdy_q;
  logic                    running_q;

  logic                    en_clk;
  logic                    bclk_rise;
  logic                    bclk_fall;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    in_slot;
  logic                    slot_done;
  logic                    frame_wrap;

  // Gating with en as well stops bclk/ws on the same edge the FSM drops to IDLE.
  assign en_clk = mic.en && (state != IDLE);

  i2s_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clock_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .en_clk    (en_clk),
    .i2s_bclk  (mic.i2s_bclk),
    .i2s_ws    (mic.i2s_ws),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall),
    .bit_cnt   (bit_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= mic.i2s_sd;
      sd_sync <= sd_meta;
    end
  end

  assign in_slot       = bclk_rise && (bit_cnt >= SLOT_FIRST) && (bit_cnt <= SLOT_LAST);
  assign slot_done     = bclk_rise && (bit_cnt == SLOT_LAST);
  // bit_cnt has already advanced when the fall strobe is seen, so a wrap reads as 0.
  assign frame_wrap    = bclk_fall && (bit_cnt == '0);
  assign shift_nxt     = {shift[SAMPLE_W-2:0], sd_sync};
  assign frame_cnt_inc = (frame_cnt == FRAME_TARGET) ? frame_cnt : frame_cnt + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      frame_cnt  <= '0;
      data_q     <= '0;
      data_rdy_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      data_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          shift     <= '0;
          frame_cnt <= '0;
          running_q <= 1'b0;
          if (mic.en) begin
            if (WARMUP_FRAMES == 0) begin
              state     <= RUN;
              running_q <= 1'b1;
            end else begin
              state <= WARMUP;
            end
          end
        end
        WARMUP: begin
          if (!mic.en) begin
            state <= IDLE;
            shift <= '0;
          end else begin
            if (in_slot) shift <= shift_nxt;
            if (frame_wrap) begin
              frame_cnt <= frame_cnt_inc;
              if (frame_cnt_inc == FRAME_TARGET) begin
                state     <= RUN;
                running_q <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (!mic.en) begin
            state     <= IDLE;
            running_q <= 1'b0;
            shift     <= '0;
          end else begin
            if (in_slot) shift <= shift_nxt;
            if (slot_done) begin
              data_q     <= shift_nxt;
              data_rdy_q <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign mic.data     = data_q;
  assign mic.data_rdy = data_rdy_q;
  assign mic.running  = running_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Two receivers on one shared stereo I2S line: left/no warm-up and right/two
// warm-up frames, checked every cycle against a time-based frame model.
module tb_i2s_mic_rx;

  localparam int D          = 4;
  localparam int FRAME_CLKS = 128 * D;
  localparam int W_B        = 2;
  localparam int NFR        = 128;
  localparam int NEVER      = 32'h7fff_ffff;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  i2s_mic_rx_if bus_a ();
  i2s_mic_rx_if bus_b ();

  i2s_mic_rx #(.CLK_DIV(D), .CHANNEL(0), .WARMUP_FRAMES(0)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .mic     (bus_a)
  );

  i2s_mic_rx #(.CLK_DIV(D), .CHANNEL(1), .WARMUP_FRAMES(W_B)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .mic     (bus_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // model state: act_cyc is the cyc value once the leave-IDLE edge has happened
  int          act_cyc  = -1;
  int          idle_cyc = NEVER;
  bit          in_reset = 1'b1;
  logic [17:0] word_l [NFR];
  logic [17:0] word_r [NFR];
  logic [17:0] held_a = '0;
  logic [17:0] held_b = '0;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          cnt_rdy_a = 0;
  int          cnt_rdy_b = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit timed();
    return !in_reset && act_cyc >= 0 && cyc >= act_cyc && cyc < idle_cyc;
  endfunction

  task automatic check_dut(input string tag, input int slot, input int warm,
                           input logic bclk, input logic ws, input logic rdy,
                           input logic run, input logic [17:0] dat,
                           inout logic [17:0] held);
    int e, r, f;
    logic eb, ews, erdy, erun;
    eb = 1'b0; ews = 1'b0; erdy = 1'b0; erun = 1'b0;
    if (in_reset) begin
      held = '0;
    end else if (timed()) begin
      e    = cyc - act_cyc;
      eb   = ((e / D) % 2) == 1;
      ews  = ((e / (2 * D)) % 64) >= 32;
      erun = (warm == 0) || (e >= FRAME_CLKS * warm + 1);
      // last bit of the slot rises at D*(2*(S+18)+1); published one clock later
      r = e - 1 - D * (2 * 32 * slot + 37);
      if (r >= 0 && (r % FRAME_CLKS) == 0 && (r / FRAME_CLKS) >= warm) begin
        f    = (r / FRAME_CLKS) % NFR;
        erdy = 1'b1;
        held = (slot == 0) ? word_l[f] : word_r[f];
      end
    end
    chk({tag, "_bclk"},     32'(bclk), 32'(eb));
    chk({tag, "_ws"},       32'(ws),   32'(ews));
    chk({tag, "_data_rdy"}, 32'(rdy),  32'(erdy));
    chk({tag, "_running"},  32'(run),  32'(erun));
    chk({tag, "_data"},     32'(dat),  32'(held));
  endtask

  // compare process plus the microphone: one shared sd line carries both slots
  initial begin
    int   e, b, pos, f;
    logic v;
    bus_a.i2s_sd = 1'b0;
    bus_b.i2s_sd = 1'b0;
    forever begin
      @(negedge clock);
      check_dut("a", 0, 0,   bus_a.i2s_bclk, bus_a.i2s_ws, bus_a.data_rdy,
                bus_a.running, bus_a.data, held_a);
      check_dut("b", 1, W_B, bus_b.i2s_bclk, bus_b.i2s_ws, bus_b.data_rdy,
                bus_b.running, bus_b.data, held_b);
      if (bus_a.data_rdy) cnt_rdy_a++;
      if (bus_b.data_rdy) cnt_rdy_b++;
      // tri-stated bit positions carry garbage
      v = 1'($urandom);
      if (timed()) begin
        e   = cyc - act_cyc;
        b   = e / (2 * D);
        pos = b % 64;
        f   = (b / 64) % NFR;
        if (pos >= 1 && pos <= 18)       v = word_l[f][18 - pos];
        else if (pos >= 33 && pos <= 50) v = word_r[f][50 - pos];
      end
      bus_a.i2s_sd = v;
      bus_b.i2s_sd = v;
    end
  end

  task automatic set_en(input logic val);
    bus_a.en = val;
    bus_b.en = val;
    if (val) begin
      act_cyc  = cyc + 1;
      idle_cyc = NEVER;
    end else begin
      idle_cyc = cyc + 1;
    end
  endtask

  task automatic wait_e(input int target);
    while (cyc - act_cyc < target) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int r1, r2, tf, tr, n;
    logic pb;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    for (int i = 0; i < NFR; i++) begin
      word_l[i] = 18'h2ABCD;
      word_r[i] = 18'h3FFFF;
    end

    repeat (3) @(negedge clock);
    chk("rst_bclk_a",    32'(bus_a.i2s_bclk), 0);
    chk("rst_data_a",    32'(bus_a.data),     0);
    chk("rst_running_b", 32'(bus_b.running),  0);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    repeat (5) @(negedge clock);

    // directed constant words
    set_en(1'b1);
    r1 = -1; r2 = -1; pb = bus_a.i2s_bclk;
    for (int i = 0; i < 100 && r2 < 0; i++) begin
      @(negedge clock);
      if (bus_a.i2s_bclk && !pb) begin
        if (r1 < 0) r1 = cyc; else r2 = cyc;
      end
      pb = bus_a.i2s_bclk;
    end
    chk("bclk_period", 32'(r2 - r1), 8);

    tf = -1; tr = -1; pb = bus_a.i2s_ws;
    for (int i = 0; i < 2000 && tr < 0; i++) begin
      @(negedge clock);
      if (!bus_a.i2s_ws && pb) tf = cyc;
      else if (bus_a.i2s_ws && !pb && tf >= 0) tr = cyc;
      pb = bus_a.i2s_ws;
    end
    chk("ws_low_clks", 32'(tr - tf), 256);

    wait_e(5 * FRAME_CLKS + 200);
    chk("lit_data_a",  32'(bus_a.data), 32'h2ABCD);
    chk("lit_data_b",  32'(bus_b.data), 32'h3FFFF);
    chk("b_not_left",  32'(bus_b.data == 18'h2ABCD), 0);
    n = 0;
    repeat (FRAME_CLKS) begin
      @(negedge clock);
      if (bus_a.data_rdy) n++;
    end
    chk("rdy_per_frame_a", 32'(n), 1);

    // drop en at bit 10 of frame 7, mid left slot
    wait_e(7 * FRAME_CLKS + 2 * D * 10 + 3);
    set_en(1'b0);
    @(negedge clock);
    chk("drop_bclk_a",    32'(bus_a.i2s_bclk), 0);
    chk("drop_ws_a",      32'(bus_a.i2s_ws),   0);
    chk("drop_running_a", 32'(bus_a.running),  0);
    chk("drop_data_a",    32'(bus_a.data),     32'h2ABCD);
    chk("drop_data_b",    32'(bus_b.data),     32'h3FFFF);
    repeat (40) @(negedge clock);

    // random words, re-enable: warm-up repeats on b
    for (int i = 0; i < NFR; i++) begin
      word_l[i] = 18'($urandom);
      word_r[i] = 18'($urandom);
    end
    cnt_rdy_a = 0;
    cnt_rdy_b = 0;
    set_en(1'b1);
    wait_e(1024);
    chk("warm_running_b_1024", 32'(bus_b.running), 0);
    wait_e(1025);
    chk("warm_running_b_1025", 32'(bus_b.running), 1);
    wait_e(100 * FRAME_CLKS + 160);
    chk("rdy_count_a", 32'(cnt_rdy_a), 101);
    chk("rdy_count_b", 32'(cnt_rdy_b), 98);

    // asynchronous reset between clock edges, en held high
    @(negedge clock);
    #3;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("arst_bclk_a",    32'(bus_a.i2s_bclk), 0);
    chk("arst_ws_a",      32'(bus_a.i2s_ws),   0);
    chk("arst_data_a",    32'(bus_a.data),     0);
    chk("arst_data_b",    32'(bus_b.data),     0);
    chk("arst_running_a", 32'(bus_a.running),  0);
    repeat (3) @(negedge clock);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    act_cyc  = cyc + 1;
    idle_cyc = NEVER;
    wait_e(D - 1);
    chk("restart_bclk_pre",   32'(bus_a.i2s_bclk), 0);
    wait_e(D);
    chk("restart_bclk_first", 32'(bus_a.i2s_bclk), 1);
    wait_e(2 * FRAME_CLKS + 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
